gpreg_file: RTL

GPREG_FILE -- requirements
Module: gpreg_file

---
 rtl/gpreg_pkg.sv | 24 ++
 rtl/gpreg_cell.sv | 26 ++
 rtl/gpreg_file.sv | 105 ++++++++++
 3 files changed

// File: rtl/gpreg_pkg.sv
// gpreg_pkg: shared defaults, FSM state encoding and clog2 helper for gpreg_file.
// Revision: 1.0
`default_nettype none

package gpreg_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_N = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpreg_cell.sv
// gpreg_cell: one W-bit storage register with synchronous clear and load.
// Revision: 1.0
`default_nettype none

module gpreg_cell #(
    parameter int W = gpreg_pkg::DEF_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear outranks load so reset and the sweep always win.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gpreg_file.sv
// gpreg_file: N x W register file with write, two-port read, swap and a clear sweep.
// Revision: 1.0
`default_nettype none

module gpreg_file
    import gpreg_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int N  = DEF_N,
    parameter int AW = clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  in,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic          swap,
    input  logic          clr,
    input  logic          csel,
    output logic [W-1:0]  outa,
    output logic [W-1:0]  outb,
    output logic [W-1:0]  outc,
    output logic [W-1:0]  oix,
    output logic          busy
);

    state_t        state;
    logic [AW-1:0] ptr;

    logic [W-1:0]  q      [N];
    logic [W-1:0]  cell_d [N];
    logic [N-1:0]  cell_clr;
    logic [N-1:0]  cell_load;

    generate
        for (genvar g = 0; g < N; g++) begin : g_cell
            gpreg_cell #(.W(W)) u_cell (
                .clk  (clk),
                .clr  (cell_clr[g]),
                .load (cell_load[g]),
                .d    (cell_d[g]),
                .q    (q[g])
            );
        end
    endgenerate

    // Commands are honoured only in IDLE; CLR outranks SWAP, which outranks WE.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cell_clr[i]  = reset || (state == SWEEP && ptr == AW'(i));
            cell_load[i] = 1'b0;
            cell_d[i]    = in;
        end
        if (state == IDLE && !clr) begin
            if (swap) begin
                if (ra != rb) begin
                    cell_load[ra] = 1'b1;
                    cell_d[ra]    = q[rb];
                    cell_load[rb] = 1'b1;
                    cell_d[rb]    = q[ra];
                end
            end else if (we) begin
                cell_load[wa] = 1'b1;
                cell_d[wa]    = in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= SWEEP;
                        ptr   <= '0;
                    end
                end
                SWEEP: begin
                    if (ptr == AW'(N - 1)) begin
                        state <= IDLE;
                    end
                    ptr <= ptr + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == SWEEP);
    assign outa = q[ra];
    assign outb = q[rb];
    assign oix  = q[N-1];
    assign outc = {W{csel}};

endmodule

`default_nettype wire
